// File: rtl/ramport_wr_arbiter_if.sv
// Requester-side bundle for the RAM write-port arbiter.
// Packed per-requester address/data lanes with a valid/ready handshake.
interface ramport_wr_arbiter_if #(
  parameter int N = 2,
  parameter int M = 4,
  parameter int R = 3
);
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_addr;
  logic [R*M-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/ramport_wr_arbiter.sv
// Round-robin owner of the RAM sync write port (we3/a3/d3).
// Clears the whole memory after reset and on clr_req.
module ramport_wr_arbiter #(
  parameter int N  = 2,
  parameter int M  = 4,
  parameter int R  = 3,
  parameter int GW = (R > 1) ? $clog2(R) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  ramport_wr_arbiter_if.slave req,
  output logic          we3,
  output logic [N-1:0]  a3,
  output logic [M-1:0]  d3,
  output logic [GW-1:0] grant_id,
  output logic [7:0]    wr_count
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_clr_ptr;
  logic [GW-1:0] r_rr;

  logic          w_run;
  logic          w_found;
  logic [GW-1:0] w_gnt;
  logic [N-1:0]  w_addr;
  logic [M-1:0]  w_data;
  logic [R-1:0]  w_ready;
  logic [GW-1:0] w_rr_nxt;

  assign w_run = (r_state == S_RUN) && !clr_req;

  // First valid requester at or after the round-robin pointer.
  always_comb begin : p_arb
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    w_addr  = '0;
    w_data  = '0;
    for (int k = 0; k < R; k++) begin
      idx = (int'(r_rr) + k) % R;
      if (!w_found && req.req_valid[GW'(idx)]) begin
        w_found = 1'b1;
        w_gnt   = GW'(idx);
        w_addr  = req.req_addr[idx*N +: N];
        w_data  = req.req_data[idx*M +: M];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_run && w_found)
      w_ready[w_gnt] = 1'b1;
  end

  assign req.req_ready = w_ready;

  assign w_rr_nxt = (w_gnt == GW'(R - 1)) ?
                    '0 : w_gnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
      r_rr      <= '0;
      we3       <= 1'b0;
      a3        <= '0;
      d3        <= '0;
      grant_id  <= '0;
      wr_count  <= '0;
      clr_busy  <= 1'b1;
    end else begin
      unique case (r_state)
        S_CLEAR: begin
          we3       <= 1'b1;
          a3        <= r_clr_ptr;
          d3        <= '0;
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (&r_clr_ptr) begin
            r_state  <= S_RUN;
            clr_busy <= 1'b0;
          end
        end
        S_RUN: begin
          if (clr_req) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            clr_busy  <= 1'b1;
            we3       <= 1'b0;
          end else if (w_found) begin
            we3      <= 1'b1;
            a3       <= w_addr;
            d3       <= w_data;
            grant_id <= w_gnt;
            r_rr     <= w_rr_nxt;
            if (wr_count != 8'hFF)
              wr_count <= wr_count + 8'd1;
          end else begin
            we3 <= 1'b0;
          end
        end
        default: begin
          r_state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramport_wr_arbiter.sv
// Random-stimulus bench for ramport_wr_arbiter.
// Abstract model: clear countdown, round-robin search, saturating count.
module tb_ramport_wr_arbiter;
  localparam int N  = 2;
  localparam int M  = 4;
  localparam int R  = 3;
  localparam int GW = 2;
  localparam int DEPTH = 1 << N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_req = 1'b0;
  logic          clr_busy;
  logic          we3;
  logic [N-1:0]  a3;
  logic [M-1:0]  d3;
  logic [GW-1:0] grant_id;
  logic [7:0]    wr_count;

  ramport_wr_arbiter_if #(.N(N), .M(M), .R(R)) bus ();

  ramport_wr_arbiter #(.N(N), .M(M), .R(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .req      (bus.slave),
    .we3      (we3),
    .a3       (a3),
    .d3       (d3),
    .grant_id (grant_id),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  logic [M-1:0] ram [DEPTH];
  always @(posedge clk)
    if (we3) ram[a3] <= d3;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // model state
  int clr_left, m_busy, m_we, m_a, m_d, m_g;
  int m_cnt, m_rr, last_acc;
  int m_mem [DEPTH];

  // requester state
  logic [R-1:0] v;
  logic [N-1:0] ad [R];
  logic [M-1:0] da [R];
  int mode, sole;
  bit force_clr;

  task automatic model_reset();
    clr_left = DEPTH;
    m_busy = 1; m_we = 0; m_a = 0; m_d = 0;
    m_g = 0; m_cnt = 0; m_rr = 0; last_acc = -1;
  endtask

  task automatic check_outputs();
    chk("we3", we3, m_we);
    chk("a3", a3, m_a);
    chk("d3", d3, m_d);
    chk("grant_id", grant_id, m_g);
    chk("wr_count", wr_count, m_cnt);
    chk("clr_busy", clr_busy, m_busy);
    for (int a = 0; a < DEPTH; a++)
      chk("ram", ram[a], m_mem[a]);
    if (m_we != 0) m_mem[m_a] = m_d;
  endtask

  task automatic drive_and_predict();
    bit creq;
    int g;
    logic [R-1:0] er;
    creq = force_clr ||
           (mode == 0 && $urandom_range(0, 29) == 0);
    force_clr = 0;
    for (int i = 0; i < R; i++) begin
      if (!(v[i] && i != last_acc)) begin
        unique case (mode)
          0: v[i] = 1'($urandom_range(0, 1));
          1: v[i] = 1'b1;
          2: v[i] = (i == sole);
          default: v[i] = 1'b0;
        endcase
        ad[i] = N'($urandom);
        da[i] = M'($urandom);
      end
    end
    clr_req = creq;
    bus.req_valid = v;
    for (int i = 0; i < R; i++) begin
      bus.req_addr[i*N +: N] = ad[i];
      bus.req_data[i*M +: M] = da[i];
    end
    #1;
    g = -1;
    if (clr_left == 0 && !creq)
      for (int k = 0; k < R; k++)
        if (g < 0 && v[(m_rr + k) % R])
          g = (m_rr + k) % R;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    last_acc = g;
    if (clr_left > 0) begin
      m_we = 1; m_a = DEPTH - clr_left; m_d = 0;
      clr_left--;
      m_busy = (clr_left != 0);
    end else if (creq) begin
      m_we = 0; m_busy = 1; clr_left = DEPTH;
    end else if (g >= 0) begin
      m_we = 1; m_a = ad[g]; m_d = da[g]; m_g = g;
      m_rr = (g + 1) % R;
      if (m_cnt < 255) m_cnt++;
    end else begin
      m_we = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    drive_and_predict();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_we3", we3, 0);
    chk("rst_busy", clr_busy, 1);
    chk("rst_a3", a3, 0);
    chk("rst_d3", d3, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_cnt", wr_count, 0);
    chk("rst_ready", bus.req_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_and_predict();
  endtask

  initial begin
    int guard;
    v = '0;
    mode = 3; sole = 0; force_clr = 0;
    for (int i = 0; i < R; i++) begin
      ad[i] = '0; da[i] = '0;
    end
    for (int a = 0; a < DEPTH; a++) begin
      ram[a] = 4'h5; m_mem[a] = 4'h5;
    end
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    repeat (8) cycle();
    mode = 0;
    repeat (300) cycle();
    // reset landing mid-clear
    force_clr = 1;
    cycle();
    guard = 0;
    while (clr_left != 2 && guard < 10) begin
      cycle(); guard++;
    end
    chk("mid_clear_reached", clr_left, 2);
    do_reset();
    repeat (6) cycle();
    mode = 1;
    repeat (40) cycle();
    mode = 2;
    sole = $urandom_range(0, R - 1);
    repeat (300) cycle();
    chk("saturated", m_cnt, 255);
    mode = 0;
    repeat (100) cycle();
    mode = 3;
    repeat (4) cycle();
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
